// File: rtl/spi_three_wire_datapath_pkg.sv
// Shared constants for the three-wire SPI datapath slice.
// Frame geometry defaults used by the datapath, its interface and the counter.
package spi3_pkg;

  localparam int WIDTH    = 16;
  localparam int CMD_BITS = 8;
  localparam int CNT_W    = 4;
  localparam int RW_BIT   = WIDTH - 1;

endpackage

// File: rtl/spi_three_wire_datapath_if.sv
// Strobe/result bundle between the SPI controller FSM and its datapath.
// master = controller side, slave = datapath side.
interface spi_three_wire_datapath_if
  import spi3_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int CB = CMD_BITS,
    parameter int CW = CNT_W
);

    logic          LDEN;
    logic          SHEN;
    logic          bitcountEN;
    logic          rstbitcount;
    logic          SCEN;
    logic          ORDY;
    logic [W-1:0]  din;
    logic          sdi;
    logic [CW-1:0] bitcount;
    logic          sdo;
    logic          sdo_oe;
    logic [W-CB-1:0] dout;
    logic          dout_valid;

    modport master (
        output LDEN, SHEN, bitcountEN, rstbitcount,
        output SCEN, ORDY, din, sdi,
        input  bitcount, sdo, sdo_oe, dout, dout_valid
    );

    modport slave (
        input  LDEN, SHEN, bitcountEN, rstbitcount,
        input  SCEN, ORDY, din, sdi,
        output bitcount, sdo, sdo_oe, dout, dout_valid
    );

endinterface

// File: rtl/spi_three_wire_datapath_counter.sv
// Clearable, enabled bit counter; wraps naturally at 2**CNT_W.
module spi3_bit_counter
  import spi3_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spi_three_wire_datapath.sv
// Three-wire SPI datapath: shift register, bit counter, line direction
// control and read-data capture on the controller's ORDY rising edge.
module spi_three_wire_datapath
  import spi3_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int CB = CMD_BITS,
    parameter int CW = CNT_W
) (
    input logic CLK,
    input logic reset,
    spi_three_wire_datapath_if.slave bus
);

    localparam int DW = W - CB;
    localparam int RW = W - 1;
    localparam logic [CW-1:0] CMD_IDX = CW'(CB);

    logic [W-1:0]  shreg_q, shreg_d;
    logic          rw_q, rw_d;
    logic          ordy_q, ordy_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dv_q, dv_d;
    logic [CW-1:0] cnt;

    spi3_bit_counter #(.CW(CW)) u_cnt (
        .CLK     (CLK),
        .reset   (reset),
        .clr_i   (bus.rstbitcount),
        .en_i    (bus.bitcountEN),
        .count_o (cnt)
    );

    // Load beats shift; ORDY edge snapshots the data byte of the frame.
    always_comb begin
        shreg_d = shreg_q;
        rw_d    = rw_q;
        if (bus.LDEN) begin
            shreg_d = bus.din;
            rw_d    = bus.din[RW];
        end else if (bus.SHEN) begin
            shreg_d = {shreg_q[W-2:0], bus.sdi};
        end
        ordy_d = bus.ORDY;
        dv_d   = bus.ORDY & ~ordy_q;
        dout_d = dv_d ? shreg_q[DW-1:0] : dout_q;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            shreg_q <= '0;
            rw_q    <= 1'b0;
            ordy_q  <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            rw_q    <= rw_d;
            ordy_q  <= ordy_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    // Release the shared line to the slave for the data phase of reads.
    assign bus.sdo_oe = reset & bus.SCEN
                      & ~(rw_q & (cnt >= CMD_IDX));
    assign bus.sdo        = reset & shreg_q[W-1];
    assign bus.bitcount   = cnt;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dv_q;

endmodule
